// File: rtl/rom_bist_misr_ctrl_pkg.sv
// Shared types and constants for the ROM BIST controller and its MISR.
package rom_bist_misr_ctrl_pkg;

  // Controller states: idle, clock-mux settle, address sweep, read-latency
  // drain, signature compare, and sticky completion.
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SETUP = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_CMP   = 3'd4,
    ST_DONE  = 3'd5
  } bist_state_e;

  // Feedback taps applied when the MISR MSB shifts out.
  localparam logic [31:0] MISR_POLY = 32'h0040_0007;

  // Value the MISR starts every run from (and sits at after reset).
  localparam logic [31:0] MISR_SEED = 32'hFFFF_FFFF;

  // True for the states in which a run is in progress and ABORT is honoured.
  function automatic logic is_run_state(input bist_state_e s);
    return (s == ST_SETUP) || (s == ST_READ) || (s == ST_DRAIN) || (s == ST_CMP);
  endfunction

endpackage

// File: rtl/rom_bist_misr.sv
// Multiple-input signature register that compacts the ROM read stream.
module rom_bist_misr
  import rom_bist_misr_ctrl_pkg::*;
#(
  parameter int BITS = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            enable,
  input  logic [BITS-1:0] data_in,
  output logic [BITS-1:0] signature
);

  localparam logic [BITS-1:0] POLY = BITS'(MISR_POLY);
  localparam logic [BITS-1:0] SEED = BITS'(MISR_SEED);

  logic [BITS-1:0] feedback;

  // Taps are folded in only when the bit being shifted out is set.
  always_comb begin
    feedback = signature[BITS-1] ? POLY : '0;
  end

  // Seed on load, otherwise shift-and-fold one data word per enabled cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      signature <= SEED;
    end else if (load) begin
      signature <= SEED;
    end else if (enable) begin
      signature <= {signature[BITS-2:0], 1'b0} ^ feedback ^ data_in;
    end
  end

endmodule

// File: rtl/rom_bist_misr_ctrl.sv
// ROM BIST controller: sweeps every ROM word once, compacts the read data
// into a MISR and compares the result against a golden signature.
module rom_bist_misr_ctrl
  import rom_bist_misr_ctrl_pkg::*;
#(
  parameter int ROM_ADDR  = 11,
  parameter int ROM_WORDS = 2048,
  parameter int ROM_BITS  = 32,
  parameter int RD_LAT    = 1,
  parameter int SETUP_CYC = 2
) (
  input  logic                BIST_CLK_ROM_IN,
  input  logic                BIST_RST_ROM_B,
  input  logic                BIST_START,
  input  logic                BIST_ABORT,
  input  logic [ROM_BITS-1:0] EXP_SIGNATURE,
  input  logic [ROM_BITS-1:0] DATA_ROM_OUT,
  output logic                BIST_ROM_ENABLE,
  output logic [ROM_ADDR-1:0] BIST_ADDR_ROM_IN,
  output logic                BIST_REN_ROM,
  output logic                BIST_BUSY,
  output logic                BIST_DONE,
  output logic                BIST_PASS,
  output logic [ROM_BITS-1:0] BIST_SIGNATURE
);

  localparam logic [ROM_ADDR-1:0] LAST_ADDR  = ROM_ADDR'(ROM_WORDS - 1);
  localparam logic [ROM_ADDR-1:0] ADDR_ONE   = ROM_ADDR'(1);
  localparam logic [2:0]          SETUP_LAST = 3'(SETUP_CYC - 1);
  localparam logic [2:0]          DRAIN_LAST = 3'(RD_LAT - 1);

  bist_state_e         state;
  logic [ROM_ADDR-1:0] addr_cnt;
  logic [2:0]          wait_cnt;
  logic [RD_LAT-1:0]   strb_pipe;
  logic                abort_req;
  logic                strobe;
  logic                misr_load;
  logic                misr_en;
  logic                busy_q;
  logic                rom_en_q;
  logic                done_q;
  logic                pass_q;

  // Abort is only meaningful while a run is active; in IDLE/DONE it is ignored.
  assign abort_req = BIST_ABORT && is_run_state(state);

  // The capture strobe is the read enable seen RD_LAT cycles later.
  assign strobe = strb_pipe[RD_LAT-1];

  // An abort freezes the MISR in the cycle it is taken, including any reseed.
  assign misr_load = (state == ST_SETUP) && !abort_req;
  assign misr_en   = strobe && !abort_req;

  // Read enable and address decode straight from the state so an abort or
  // reset drops them in the very next cycle without an extra register stage.
  assign BIST_REN_ROM     = (state == ST_READ);
  assign BIST_ADDR_ROM_IN = (state == ST_READ) ? addr_cnt : '0;

  assign BIST_BUSY       = busy_q;
  assign BIST_ROM_ENABLE = rom_en_q;
  assign BIST_DONE       = done_q;
  assign BIST_PASS       = pass_q;

  // Run sequencing with registered status outputs updated alongside the state.
  always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_ROM_B) begin
    if (!BIST_RST_ROM_B) begin
      state    <= ST_IDLE;
      addr_cnt <= '0;
      wait_cnt <= '0;
      busy_q   <= 1'b0;
      rom_en_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else if (abort_req) begin
      state    <= ST_IDLE;
      addr_cnt <= '0;
      wait_cnt <= '0;
      busy_q   <= 1'b0;
      rom_en_q <= 1'b0;
      done_q   <= 1'b0;
      pass_q   <= 1'b0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (BIST_START) begin
            state    <= ST_SETUP;
            addr_cnt <= '0;
            wait_cnt <= '0;
            busy_q   <= 1'b1;
            rom_en_q <= 1'b1;
            done_q   <= 1'b0;
            pass_q   <= 1'b0;
          end
        end
        ST_SETUP: begin
          addr_cnt <= '0;
          if (wait_cnt == SETUP_LAST) begin
            state    <= ST_READ;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_READ: begin
          if (addr_cnt == LAST_ADDR) begin
            state    <= ST_DRAIN;
            addr_cnt <= '0;
          end else begin
            addr_cnt <= addr_cnt + ADDR_ONE;
          end
        end
        ST_DRAIN: begin
          if (wait_cnt == DRAIN_LAST) begin
            state    <= ST_CMP;
            wait_cnt <= '0;
          end else begin
            wait_cnt <= wait_cnt + 3'd1;
          end
        end
        ST_CMP: begin
          state    <= ST_DONE;
          pass_q   <= (BIST_SIGNATURE == EXP_SIGNATURE);
          done_q   <= 1'b1;
          busy_q   <= 1'b0;
          rom_en_q <= 1'b0;
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  // Delay line matching the ROM read latency; emptied on abort so no stale
  // capture can land after the run is abandoned.
  always_ff @(posedge BIST_CLK_ROM_IN or negedge BIST_RST_ROM_B) begin
    if (!BIST_RST_ROM_B) begin
      strb_pipe <= '0;
    end else if (abort_req) begin
      strb_pipe <= '0;
    end else begin
      strb_pipe[0] <= BIST_REN_ROM;
      for (int i = 1; i < RD_LAT; i++) begin
        strb_pipe[i] <= strb_pipe[i-1];
      end
    end
  end

  rom_bist_misr #(
    .BITS(ROM_BITS)
  ) u_misr (
    .clk       (BIST_CLK_ROM_IN),
    .rst_n     (BIST_RST_ROM_B),
    .load      (misr_load),
    .enable    (misr_en),
    .data_in   (DATA_ROM_OUT),
    .signature (BIST_SIGNATURE)
  );

endmodule

// File: tb/tb_rom_bist_misr_ctrl.sv
// Self-checking bench for rom_bist_misr_ctrl: one instance at default
// parameters and one with a three-cycle ROM read latency, each fed by a
// behavioural ROM built on a shared content array.
module tb_rom_bist_misr_ctrl;

  localparam int          ADDR_W       = 11;
  localparam int          WORDS        = 2048;
  localparam int          SETUP_CYC    = 2;
  localparam int          CYCLE_BUDGET = 3000;
  localparam logic [31:0] POLY         = 32'h0040_0007;
  localparam logic [31:0] SEED         = 32'hFFFF_FFFF;

  typedef struct {
    logic start;
    logic abort;
    logic busy;
    logic rom_en;
    logic ren;
    logic done;
    int   addr;
  } vec_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  logic [1:0]       start_v;
  logic [1:0]       abort_v;
  logic [1:0][31:0] exp_v;

  logic              rom_en0, ren0, busy0, done0, pass0;
  logic              rom_en1, ren1, busy1, done1, pass1;
  logic [ADDR_W-1:0] addr0, addr1;
  logic [31:0]       sig0, sig1;

  logic [1:0]              rom_en_o, ren_o, busy_o, done_o, pass_o;
  logic [1:0][ADDR_W-1:0]  addr_o;
  logic [1:0][31:0]        sig_o;

  logic [31:0] mem [WORDS];
  logic [31:0] rom0_q, rom1_p1, rom1_p2, rom1_p3;

  vec_t vecs [10];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign rom_en_o = {rom_en1, rom_en0};
  assign ren_o    = {ren1, ren0};
  assign busy_o   = {busy1, busy0};
  assign done_o   = {done1, done0};
  assign pass_o   = {pass1, pass0};
  assign addr_o   = {addr1, addr0};
  assign sig_o    = {sig1, sig0};

  // Behavioural ROMs: one-cycle and three-cycle registered reads of mem.
  always @(posedge clk) begin
    rom0_q  <= mem[addr0];
    rom1_p1 <= mem[addr1];
    rom1_p2 <= rom1_p1;
    rom1_p3 <= rom1_p2;
  end

  rom_bist_misr_ctrl dut0 (
    .BIST_CLK_ROM_IN  (clk),
    .BIST_RST_ROM_B   (rst_n),
    .BIST_START       (start_v[0]),
    .BIST_ABORT       (abort_v[0]),
    .EXP_SIGNATURE    (exp_v[0]),
    .DATA_ROM_OUT     (rom0_q),
    .BIST_ROM_ENABLE  (rom_en0),
    .BIST_ADDR_ROM_IN (addr0),
    .BIST_REN_ROM     (ren0),
    .BIST_BUSY        (busy0),
    .BIST_DONE        (done0),
    .BIST_PASS        (pass0),
    .BIST_SIGNATURE   (sig0)
  );

  rom_bist_misr_ctrl #(
    .RD_LAT(3)
  ) dut1 (
    .BIST_CLK_ROM_IN  (clk),
    .BIST_RST_ROM_B   (rst_n),
    .BIST_START       (start_v[1]),
    .BIST_ABORT       (abort_v[1]),
    .EXP_SIGNATURE    (exp_v[1]),
    .DATA_ROM_OUT     (rom1_p3),
    .BIST_ROM_ENABLE  (rom_en1),
    .BIST_ADDR_ROM_IN (addr1),
    .BIST_REN_ROM     (ren1),
    .BIST_BUSY        (busy1),
    .BIST_DONE        (done1),
    .BIST_PASS        (pass1),
    .BIST_SIGNATURE   (sig1)
  );

  function automatic int lat_of(input int d);
    return (d == 0) ? 1 : 3;
  endfunction

  // Signature after compacting the first n ROM words starting from the seed.
  function automatic logic [31:0] ref_signature(input int n);
    logic [31:0] s;
    s = SEED;
    for (int a = 0; a < n; a++) begin
      s = (s << 1) ^ (s[31] ? POLY : 32'h0) ^ mem[a];
    end
    return s;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic start, input logic abort);
    start_v[0] = start;
    abort_v[0] = abort;
  endtask

  task automatic check_idle_outputs(input string tag, input int d);
    checkOutput($sformatf("%s_dut%0d_ren", tag, d), 32'(ren_o[d]), 32'd0);
    checkOutput($sformatf("%s_dut%0d_busy", tag, d), 32'(busy_o[d]), 32'd0);
    checkOutput($sformatf("%s_dut%0d_rom_en", tag, d), 32'(rom_en_o[d]), 32'd0);
    checkOutput($sformatf("%s_dut%0d_done", tag, d), 32'(done_o[d]), 32'd0);
    checkOutput($sformatf("%s_dut%0d_pass", tag, d), 32'(pass_o[d]), 32'd0);
    checkOutput($sformatf("%s_dut%0d_addr", tag, d), 32'(addr_o[d]), 32'd0);
  endtask

  // Complete run from IDLE or DONE, checking timing, address sweep and result.
  task automatic run_full(input int d, input logic [31:0] exp_sig, input logic exp_pass, input logic [31:0] ref_sig);
    int ren_cnt, first_ren, last_ren, done_cyc, addr_bad;
    ren_cnt = 0; first_ren = -1; last_ren = -1; done_cyc = -1; addr_bad = 0;
    exp_v[d]   = exp_sig;
    start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int cyc = 0; cyc < CYCLE_BUDGET; cyc++) begin
      if (cyc == 0) begin
        checkOutput($sformatf("dut%0d_setup_busy", d), 32'(busy_o[d]), 32'd1);
        checkOutput($sformatf("dut%0d_setup_rom_en", d), 32'(rom_en_o[d]), 32'd1);
        checkOutput($sformatf("dut%0d_setup_done_clr", d), 32'(done_o[d]), 32'd0);
        checkOutput($sformatf("dut%0d_setup_pass_clr", d), 32'(pass_o[d]), 32'd0);
      end
      if (cyc == 1) begin
        checkOutput($sformatf("dut%0d_setup_seed", d), sig_o[d], SEED);
      end
      if (ren_o[d]) begin
        if (first_ren < 0) first_ren = cyc;
        last_ren = cyc;
        if (32'(addr_o[d]) != 32'(ren_cnt)) addr_bad++;
        ren_cnt++;
      end else if (addr_o[d] != '0) begin
        addr_bad++;
      end
      if (done_o[d]) begin
        done_cyc = cyc;
        break;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("dut%0d_done_cycle", d), 32'(done_cyc), 32'(SETUP_CYC + WORDS + lat_of(d) + 1));
    checkOutput($sformatf("dut%0d_ren_count", d), 32'(ren_cnt), 32'(WORDS));
    checkOutput($sformatf("dut%0d_first_ren", d), 32'(first_ren), 32'(SETUP_CYC));
    checkOutput($sformatf("dut%0d_ren_span", d), 32'(last_ren - first_ren + 1), 32'(WORDS));
    checkOutput($sformatf("dut%0d_addr_seq_errs", d), 32'(addr_bad), 32'd0);
    checkOutput($sformatf("dut%0d_signature", d), sig_o[d], ref_sig);
    checkOutput($sformatf("dut%0d_pass", d), 32'(pass_o[d]), 32'(exp_pass));
    checkOutput($sformatf("dut%0d_done_busy", d), 32'(busy_o[d]), 32'd0);
    checkOutput($sformatf("dut%0d_done_rom_en", d), 32'(rom_en_o[d]), 32'd0);
    repeat (3) @(negedge clk);
    checkOutput($sformatf("dut%0d_done_sticky", d), 32'(done_o[d]), 32'd1);
    checkOutput($sformatf("dut%0d_pass_sticky", d), 32'(pass_o[d]), 32'(exp_pass));
  endtask

  // Start a run, abort it while address k is on the bus, and check the aftermath.
  task automatic abort_run(input int d, input int k);
    bit          found;
    int          bad;
    logic [31:0] part;
    found = 1'b0;
    start_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[d] = 1'b0;
    for (int cyc = 0; cyc < CYCLE_BUDGET; cyc++) begin
      if (ren_o[d] && (32'(addr_o[d]) == 32'(k))) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    checkOutput($sformatf("dut%0d_abort_reached_addr", d), 32'(found), 32'd1);
    abort_v[d] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    abort_v[d] = 1'b0;
    check_idle_outputs("abort", d);
    part = ref_signature(k - lat_of(d));
    checkOutput($sformatf("dut%0d_abort_sig_hold", d), sig_o[d], part);
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (ren_o[d] || busy_o[d]) bad++;
    end
    checkOutput($sformatf("dut%0d_abort_quiet", d), 32'(bad), 32'd0);
    checkOutput($sformatf("dut%0d_abort_sig_still", d), sig_o[d], part);
  endtask

  // Assert reset asynchronously partway through a sweep on the default instance.
  task automatic reset_mid_run();
    int bad;
    start_v[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (40) @(negedge clk);
    checkOutput("rst_pre_ren", 32'(ren_o[0]), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_mid", 0);
    checkOutput("rst_mid_sig", sig_o[0], SEED);
    @(negedge clk);
    rst_n = 1'b1;
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (ren_o[0] || busy_o[0]) bad++;
    end
    checkOutput("rst_after_quiet", 32'(bad), 32'd0);
  endtask

  initial begin
    logic [31:0] refv;

    // Cycle-level control vectors for the default instance, starting in IDLE.
    vecs[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[2] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[3] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 0};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1};
    vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2};
    vecs[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[7] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 0};
    vecs[8] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 0};
    vecs[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 0};

    start_v = '0;
    abort_v = '0;
    exp_v   = '0;
    for (int a = 0; a < WORDS; a++) mem[a] = 32'(a);

    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check_idle_outputs("reset", d);
      checkOutput($sformatf("reset_dut%0d_sig", d), sig_o[d], SEED);
    end
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      applyStimulus(vecs[i].start, vecs[i].abort);
      @(posedge clk);
      @(negedge clk);
      checkOutput($sformatf("vec%0d_busy", i), 32'(busy_o[0]), 32'(vecs[i].busy));
      checkOutput($sformatf("vec%0d_rom_en", i), 32'(rom_en_o[0]), 32'(vecs[i].rom_en));
      checkOutput($sformatf("vec%0d_ren", i), 32'(ren_o[0]), 32'(vecs[i].ren));
      checkOutput($sformatf("vec%0d_done", i), 32'(done_o[0]), 32'(vecs[i].done));
      checkOutput($sformatf("vec%0d_addr", i), 32'(addr_o[0]), 32'(vecs[i].addr));
    end
    applyStimulus(1'b0, 1'b0);

    refv = ref_signature(WORDS);
    run_full(0, refv, 1'b1, refv);
    run_full(0, refv ^ 32'h1, 1'b0, refv);
    run_full(1, refv, 1'b1, refv);
    abort_run(0, 100);
    run_full(0, refv, 1'b1, refv);
    reset_mid_run();

    for (int r = 0; r < 4; r++) begin
      int          d;
      int          mode;
      logic [31:0] rv;
      d    = int'($urandom_range(0, 1));
      mode = int'($urandom_range(0, 2));
      for (int a = 0; a < WORDS; a++) mem[a] = $urandom;
      rv = ref_signature(WORDS);
      case (mode)
        0: run_full(d, rv, 1'b1, rv);
        1: run_full(d, rv ^ (32'h1 << $urandom_range(0, 31)), 1'b0, rv);
        default: begin
          abort_run(d, int'($urandom_range(3, WORDS - 1)));
          run_full(d, rv, 1'b1, rv);
        end
      endcase
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
